// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller for the register-heap + ALU datapath: decodes R-type words and
// generates one-cycle RR/EX/WB phase strobes. Optional build macro: ZERO_REG_GUARD_EN (rd==0 not written).
module alu_issue_ctrl #(
    parameter int EX_CYCLES = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             clk_rst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [31:0]      inst,
    output logic [4:0]       R_Addr_A,
    output logic [4:0]       R_Addr_B,
    output logic [4:0]       W_Addr,
    output logic [3:0]       ALU_OP,
    output logic             Reg_Write,
    output logic             rr_en,
    output logic             f_en,
    output logic             wb_en,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // state | meaning
    // IDLE  | waiting for an instruction, inst_ready=1
    // RR    | register read, rr_en strobe
    // EX    | ALU settle for EX_CYCLES cycles, f_en on the first cycle
    // WB    | write-back, done strobe; may accept the next instruction
    typedef enum logic [1:0] {IDLE, RR, EX, WB} state_t;

    localparam logic [3:0] EX_LOAD = 4'(EX_CYCLES - 1);

    state_t     state;
    logic [3:0] ex_cnt;
    logic       legal_q;
    logic       accept;
    logic       dec_legal;
    logic [3:0] dec_op;
    logic       wr_ok;
    logic       unused_shamt;

    assign inst_ready   = (state == IDLE) || (state == WB);
    assign accept       = inst_valid && inst_ready;
    assign unused_shamt = ^inst[10:6];

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 4'd0;
        if (inst[31:26] == 6'd0) begin
            dec_legal = 1'b1;
            case (inst[5:0])
                6'h20:   dec_op = 4'd0;
                6'h22:   dec_op = 4'd1;
                6'h24:   dec_op = 4'd2;
                6'h25:   dec_op = 4'd3;
                6'h26:   dec_op = 4'd4;
                6'h27:   dec_op = 4'd5;
                6'h2A:   dec_op = 4'd6;
                6'h04:   dec_op = 4'd7;
                default: dec_legal = 1'b0;
            endcase
        end
    end

`ifdef ZERO_REG_GUARD_EN
    assign wr_ok = legal_q && (W_Addr != 5'd0);
`else
    assign wr_ok = legal_q;
`endif

    always_ff @(posedge clk) begin
        if (clk_rst) begin
            state     <= IDLE;
            ex_cnt    <= 4'd0;
            legal_q   <= 1'b0;
            R_Addr_A  <= 5'd0;
            R_Addr_B  <= 5'd0;
            W_Addr    <= 5'd0;
            ALU_OP    <= 4'd0;
            Reg_Write <= 1'b0;
            rr_en     <= 1'b0;
            f_en      <= 1'b0;
            wb_en     <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            rr_en     <= 1'b0;
            f_en      <= 1'b0;
            wb_en     <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            Reg_Write <= 1'b0;

            if (accept) begin
                R_Addr_A <= inst[25:21];
                R_Addr_B <= inst[20:16];
                W_Addr   <= inst[15:11];
                ALU_OP   <= dec_legal ? dec_op : 4'd0;
                legal_q  <= dec_legal;
            end

            case (state)
                IDLE, WB: begin
                    if (accept) begin
                        state <= RR;
                        rr_en <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RR: begin
                    state  <= EX;
                    ex_cnt <= EX_LOAD;
                    f_en   <= 1'b1;
                end
                EX: begin
                    // strobes are registered, so the WB outputs are set on the edge entering WB
                    if (ex_cnt == 4'd0) begin
                        state     <= WB;
                        wb_en     <= 1'b1;
                        done      <= 1'b1;
                        Reg_Write <= wr_ok;
                        illegal   <= !legal_q;
                        if (wr_ok) retired <= retired + 1'b1;
                    end else begin
                        ex_cnt <= ex_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: per-instruction timeline model (phase = cycles since accept)
// compared cycle by cycle against the DUT outputs.
module tb_alu_issue_ctrl;

    localparam int EX = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          clk_rst;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [4:0]    R_Addr_A, R_Addr_B, W_Addr;
    logic [3:0]    ALU_OP;
    logic          Reg_Write, rr_en, f_en, wb_en, done, illegal;
    logic [CW-1:0] retired;

    alu_issue_ctrl #(.EX_CYCLES(EX), .CNT_W(CW)) dut (
        .clk(clk), .clk_rst(clk_rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
        .ALU_OP(ALU_OP), .Reg_Write(Reg_Write), .rr_en(rr_en), .f_en(f_en),
        .wb_en(wb_en), .done(done), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ALU op for a word, or -1 when the word is not a legal R-type
    function automatic int m_decode(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (op != 6'd0) return -1;
        case (fn)
            6'h20: return 0;
            6'h22: return 1;
            6'h24: return 2;
            6'h25: return 3;
            6'h26: return 4;
            6'h27: return 5;
            6'h2A: return 6;
            6'h04: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] fn);
        return {op, rs, rt, rd, 5'd0, fn};
    endfunction

    int          cyc;
    bit          active;
    int          a_cyc;
    logic [31:0] m_inst;
    int          m_op;
    bit          m_wr;
    bit          counted;
    int          exp_ret;
    bit          rst_zero;
    bit          pend;
    bit          did_dir_rst;
    logic [31:0] dir_q[$];

    initial begin
        logic [5:0] legal_fn[8];
        int  p;
        bit  in_flight, e_ready, e_wb;
        int  r;
        logic [31:0] w;

        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h04};
        dir_q.push_back(32'h014B4820);
        dir_q.push_back(mk(6'h00, 5'd1, 5'd2, 5'd3, 6'h22));
        dir_q.push_back(mk(6'h00, 5'd4, 5'd5, 5'd6, 6'h2A));
        dir_q.push_back(mk(6'h08, 5'd7, 5'd8, 5'd9, 6'h20));
        dir_q.push_back(mk(6'h00, 5'd7, 5'd8, 5'd9, 6'h3F));
        dir_q.push_back(mk(6'h00, 5'd12, 5'd13, 5'd0, 6'h20));

        clk_rst = 1'b1; inst_valid = 1'b0; inst = 32'd0;
        repeat (2) @(posedge clk);
        cyc = 0; active = 0; a_cyc = 0; exp_ret = 0; rst_zero = 1; pend = 0;
        counted = 0; m_wr = 0; m_op = 0; m_inst = 0; did_dir_rst = 0;

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            p = active ? (cyc - a_cyc) : 0;
            in_flight = active && (p >= 1) && (p <= EX + 2);
            e_ready   = !in_flight || (p == EX + 2);
            e_wb      = in_flight && (p == EX + 2);
            if (e_wb && m_wr && !counted) begin
                exp_ret = (exp_ret + 1) % (1 << CW);
                counted = 1;
            end
            chk("inst_ready", 32'(inst_ready), 32'(e_ready));
            chk("rr_en",      32'(rr_en),      32'(in_flight && p == 1));
            chk("f_en",       32'(f_en),       32'(in_flight && p == 2));
            chk("wb_en",      32'(wb_en),      32'(e_wb));
            chk("done",       32'(done),       32'(e_wb));
            chk("Reg_Write",  32'(Reg_Write),  32'(e_wb && m_wr));
            chk("illegal",    32'(illegal),    32'(e_wb && m_op < 0));
            chk("retired",    32'(retired),    32'(exp_ret));
            if (in_flight) begin
                chk("R_Addr_A", 32'(R_Addr_A), 32'(m_inst[25:21]));
                chk("R_Addr_B", 32'(R_Addr_B), 32'(m_inst[20:16]));
                chk("W_Addr",   32'(W_Addr),   32'(m_inst[15:11]));
                chk("ALU_OP",   32'(ALU_OP),   (m_op < 0) ? 32'd0 : 32'(m_op));
            end else if (rst_zero) begin
                chk("rst_addr", 32'({R_Addr_A, R_Addr_B, W_Addr}), 32'd0);
                chk("rst_op",   32'(ALU_OP), 32'd0);
            end

            // drive inputs for this cycle
            clk_rst = 1'b0;
            if (in_flight && p >= 2 && p <= EX + 1) begin
                if ((dir_q.size() == 0 && !did_dir_rst && !pend) || ($urandom_range(0, 39) == 0)) begin
                    clk_rst = 1'b1;
                    did_dir_rst = 1;
                end
            end
            if (!pend) begin
                if (dir_q.size() != 0) begin
                    inst = dir_q.pop_front();
                    inst_valid = 1'b1;
                    pend = 1;
                end else if (did_dir_rst && $urandom_range(0, 9) < 6) begin
                    r = $urandom_range(0, 9);
                    w = $urandom;
                    w[31:26] = 6'd0;
                    w[5:0] = legal_fn[$urandom_range(0, 7)];
                    if (r == 0) w[31:26] = 6'($urandom_range(1, 63));
                    if (r == 1) w[5:0] = 6'($urandom);
                    if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
                    inst = w;
                    inst_valid = 1'b1;
                    pend = 1;
                end else begin
                    inst_valid = 1'b0;
                end
            end

            @(posedge clk);
            if (clk_rst) begin
                active = 0; exp_ret = 0; rst_zero = 1;
            end else if (inst_valid && e_ready) begin
                active = 1; a_cyc = cyc; m_inst = inst; m_op = m_decode(inst);
                counted = 0; rst_zero = 0; pend = 0;
`ifdef ZERO_REG_GUARD_EN
                m_wr = (m_op >= 0) && (inst[15:11] != 5'd0);
`else
                m_wr = (m_op >= 0);
`endif
            end
            cyc++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
